// File: rtl/vec_lane_drain_seq_pkg.sv
// Shared constants and FSM encoding for the vector lane drain sequencer.
package vec_lane_drain_seq_pkg;

    localparam int unsigned K      = 8;
    localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SUM_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/vec_lane_drain_seq_if.sv
// Output element stream: valid/ready handshake carrying one 32-bit lane value per beat.
interface vec_lane_drain_seq_if;
    import vec_lane_drain_seq_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/vec_lane_drain_seq_lane_idx_wrap.sv
// Next lane index: (idx + stride) mod K with explicit wrap, so K need not be a power of two.
module vec_lane_drain_seq_lane_idx_wrap
    import vec_lane_drain_seq_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] stride,
    output logic [IDX_W-1:0] idx_nxt_c
);

    logic [SUM_W-1:0] stride_m;
    logic [SUM_W-1:0] sum;

    // stride < 2^IDX_W < 2K and idx < K, so one conditional subtract per step suffices
    always_comb begin
        stride_m = {1'b0, stride};
        if (stride_m >= SUM_W'(K)) begin
            stride_m = stride_m - SUM_W'(K);
        end
        sum = {1'b0, idx} + stride_m;
        if (sum >= SUM_W'(K)) begin
            sum = sum - SUM_W'(K);
        end
        idx_nxt_c = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/vec_lane_drain_seq.sv
// Streams lanes of a K-lane vector register as 32-bit scalars by stepping the
// lane-select index with a wrapping stride and forwarding the selected data.
module vec_lane_drain_seq
    import vec_lane_drain_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            start_idx,
    input  logic [IDX_W-1:0]       stride,
    input  logic [CNT_W-1:0]       count,
    input  logic                   abort,
    output logic [31:0]            sel_k,
    input  logic [DATA_W-1:0]      sel_data,
    vec_lane_drain_seq_if.master   out_if,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_nxt_c;
    logic              beat_c;

    vec_lane_drain_seq_lane_idx_wrap u_wrap (
        .idx       (idx_q),
        .stride    (stride),
        .idx_nxt_c (idx_nxt_c)
    );

    assign beat_c = out_valid_q & out_if.out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        remain_d = remain_q;
        err_d    = err_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_idx >= 32'(K)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (count == '0) begin
                        err_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d    = start_idx[IDX_W-1:0];
                        remain_d = count;
                        err_d    = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (beat_c) begin
                    remain_d = remain_q - CNT_W'(1);
                    idx_d    = idx_nxt_c;
                end
                // abort wins over further beats; a beat in the same cycle still counts
                if (abort || (beat_c && out_last_q)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN);
        out_last_d  = (state_d == ST_RUN) && (remain_d == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            remain_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remain_q    <= remain_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sel_k            = 32'(idx_q);
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign out_if.out_data  = sel_data;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_vec_lane_drain_seq.sv
// Bench for vec_lane_drain_seq: selectunit model, directed drains, randomized drains,
// and a transaction-level reference model checked every cycle.
module tb_vec_lane_drain_seq;
    import vec_lane_drain_seq_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [31:0]       start_idx = '0;
    logic [IDX_W-1:0]  stride = '0;
    logic [CNT_W-1:0]  count = '0;
    logic [31:0]       sel_k;
    logic [31:0]       sel_data;
    logic              busy, done, err;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    logic [31:0] got[$];

    // reference model state: drain described by its parameters and beats delivered
    int   m_mode = 0;
    int   m_start = 0, m_stride = 0, m_count = 0, m_beats = 0;
    logic m_err = 1'b0, m_done = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    vec_lane_drain_seq_if io();

    always #5 clk = ~clk;

    // selectunit model: lane i holds A000_0000+i, out-of-range falls back to lane 0
    assign sel_data = (sel_k < 32'(K)) ? (32'hA000_0000 + sel_k) : 32'hA000_0000;

    vec_lane_drain_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .start_idx (start_idx),
        .stride    (stride),
        .count     (count),
        .abort     (abort),
        .sel_k     (sel_k),
        .sel_data  (sel_data),
        .out_if    (io),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       io.out_ready = 1'b1;
            1:       io.out_ready = ~io.out_ready;
            default: io.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic issue(input int si, input int st, input int c);
        start     = 1'b1;
        start_idx = 32'(si);
        stride    = IDX_W'(st);
        count     = CNT_W'(c);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int n_cyc);
        int n = 0;
        while (!done && n < budget) begin
            abort = rnd && ($urandom_range(0, 19) == 0);
            start = rnd && ($urandom_range(0, 9) == 0);
            if (start) begin
                start_idx = 32'($urandom_range(0, 9));
                count     = CNT_W'($urandom_range(0, 12));
            end
            tick();
            n++;
        end
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, budget);
        end
        n_cyc = n;
        tick();
    endtask

    // per-cycle compare against the model, then advance the model on this cycle's inputs
    always @(negedge clk) begin
        int  lane;
        bit  beat;
        bit  nd;
        if (!reset_n) begin
            chk("rst_valid", 32'(io.out_valid), 32'd0);
            chk("rst_last",  32'(io.out_last),  32'd0);
            chk("rst_busy",  32'(busy),         32'd0);
            chk("rst_done",  32'(done),         32'd0);
            chk("rst_err",   32'(err),          32'd0);
            chk("rst_sel_k", sel_k,             32'd0);
            m_mode = 0; m_start = 0; m_stride = 0; m_count = 0; m_beats = 0;
            m_err = 1'b0; m_done = 1'b0; prev_stall = 1'b0;
        end else begin
            lane = int'((m_start + m_beats * m_stride) % K);
            chk("valid", 32'(io.out_valid), 32'(m_mode == 1));
            chk("busy",  32'(busy),         32'(m_mode == 1));
            chk("done",  32'(done),         32'(m_done));
            chk("err",   32'(err),          32'(m_err));
            chk("sel_k", sel_k,             32'(lane));
            if (m_mode == 1) begin
                chk("data", io.out_data, 32'hA000_0000 + 32'(lane));
                chk("last", 32'(io.out_last), 32'(m_beats == m_count - 1));
            end else begin
                chk("last_idle", 32'(io.out_last), 32'd0);
            end
            if (prev_stall) chk("stall_hold", io.out_data, prev_data);
            prev_stall = io.out_valid && !io.out_ready;
            prev_data  = io.out_data;

            nd = 1'b0;
            case (m_mode)
                0: if (start) begin
                    if (start_idx >= 32'(K)) begin
                        m_err = 1'b1; nd = 1'b1;
                    end else if (count == 0) begin
                        m_err = 1'b0; nd = 1'b1;
                    end else begin
                        m_err = 1'b0;
                        m_start = int'(start_idx); m_stride = int'(stride);
                        m_count = int'(count); m_beats = 0;
                        m_mode = 1;
                    end
                end
                1: begin
                    beat = io.out_ready;
                    if (beat) begin
                        got.push_back(io.out_data);
                        m_beats++;
                    end
                    if (abort || (beat && m_beats == m_count)) begin
                        m_mode = 2; nd = 1'b1;
                    end
                end
                default: m_mode = 0;
            endcase
            m_done = nd;
        end
    end

    logic [31:0] exp1 [8] = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0005,
                              32'hA000_0006, 32'hA000_0007, 32'hA000_0000, 32'hA000_0001};
    logic [31:0] exp2 [4] = '{32'hA000_0005, 32'hA000_0000, 32'hA000_0003, 32'hA000_0006};
    logic [31:0] exp6 [3] = '{32'hA000_0006, 32'hA000_0000, 32'hA000_0002};

    initial begin
        int n;
        io.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // 1: contiguous wrap at full throughput
        rdy_mode = 0; got.delete();
        issue(2, 1, 8);
        wait_done(100, 1'b0, n);
        chk("t1_cycles", 32'(n), 32'd8);
        chk("t1_beats", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++) chk($sformatf("t1_d%0d", i), got[i], exp1[i]);

        // 2: stride 3 with toggling ready
        rdy_mode = 1; got.delete();
        issue(5, 3, 4);
        wait_done(100, 1'b0, n);
        chk("t2_beats", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk($sformatf("t2_d%0d", i), got[i], exp2[i]);

        // 3: out-of-range start sets err, next good start clears it
        rdy_mode = 0; got.delete();
        issue(9, 1, 4);
        chk("t3_err", 32'(err), 32'd1);
        wait_done(10, 1'b0, n);
        chk("t3_beats", 32'(got.size()), 32'd0);
        issue(0, 1, 2);
        chk("t3_err_clr", 32'(err), 32'd0);
        wait_done(100, 1'b0, n);
        chk("t3_beats2", 32'(got.size()), 32'd2);

        // 4: zero count, then start during RUN is ignored
        got.delete();
        issue(1, 1, 0);
        wait_done(10, 1'b0, n);
        chk("t4_zero_beats", 32'(got.size()), 32'd0);
        issue(0, 1, 5);
        tick();
        start = 1'b1; start_idx = 32'd3; count = CNT_W'(9);
        tick();
        start = 1'b0;
        wait_done(100, 1'b0, n);
        chk("t4_beats", 32'(got.size()), 32'd5);

        // 5: abort together with the third beat
        got.delete();
        issue(0, 1, 6);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_beats", 32'(got.size()), 32'd3);
        wait_done(10, 1'b0, n);

        // 6: asynchronous reset mid-drain, then a fresh drain
        issue(4, 1, 20);
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(io.out_valid), 32'd0);
        chk("t6_busy",  32'(busy),         32'd0);
        chk("t6_sel_k", sel_k,             32'd0);
        chk("t6_done",  32'(done),         32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        got.delete();
        issue(6, 2, 3);
        wait_done(100, 1'b0, n);
        chk("t6_beats", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("t6_d%0d", i), got[i], exp6[i]);

        // randomized drains with random ready, aborts and spurious starts
        rdy_mode = 2;
        for (int t = 0; t < 80; t++) begin
            issue(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
            wait_done(300, 1'b1, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
